// File: rtl/compat_trig_sched.sv
// Compatibility trigger scheduler.
// Collects masked trigger requests between 40 MHz ticks, issues one trigger
// per tick when the event buffer can take it, waits for acknowledge (with a
// 256-cycle timeout), then holds off for DEAD_TIME cycles. Requests seen on a
// tick that cannot be serviced are counted as lost.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a tick with pending requests
// ISSUE    | TRIG_OUT pulse cycle, TRIG_TYPE just latched
// WAIT_ACK | waiting for TRIG_ACK or the 256-cycle timeout
// DEAD     | post-acknowledge hold-off, counting DCNT down to zero
module compat_trig_sched #(
    parameter int NSRC     = 4,
    parameter int DT_WIDTH = 12
) (
    input  logic                CLK120,
    input  logic                RESET,
    input  logic [1:0]          ENABLE40,
    input  logic [NSRC-1:0]     TRIG_IN,
    input  logic [NSRC-1:0]     TRIG_MASK,
    input  logic [DT_WIDTH-1:0] DEAD_TIME,
    input  logic                BUF_READY,
    input  logic                TRIG_ACK,
    output logic                TRIG_OUT,
    output logic [NSRC-1:0]     TRIG_TYPE,
    output logic                BUSY,
    output logic [15:0]         LOST_COUNT,
    output logic                ACK_TIMEOUT
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        DEAD     = 2'd3
    } state_t;

    state_t                state;
    logic [1:0]            lcl_enable40;
    logic [NSRC-1:0]       pending;
    logic [DT_WIDTH-1:0]   dcnt;
    logic [7:0]            tmo_cnt;

    logic                  tick;
    logic [NSRC-1:0]       new_req;
    logic                  take;
    logic                  lose;

    // Tick detection and request qualification; a tick with pending requests
    // always consumes them, either as a trigger or as a lost count.
    always_comb begin
        tick    = (lcl_enable40 == 2'd0);
        new_req = TRIG_IN & TRIG_MASK;
        take    = tick && (pending != '0);
        lose    = take && ((state != IDLE) || !BUF_READY);
    end

    // Scheduler FSM with registered outputs, request accumulator and counters.
    always_ff @(posedge CLK120) begin
        if (RESET) begin
            state        <= IDLE;
            lcl_enable40 <= 2'd0;
            pending      <= '0;
            TRIG_OUT     <= 1'b0;
            TRIG_TYPE    <= '0;
            BUSY         <= 1'b0;
            LOST_COUNT   <= 16'd0;
            ACK_TIMEOUT  <= 1'b0;
            dcnt         <= '0;
            tmo_cnt      <= 8'd0;
        end else begin
            lcl_enable40 <= ENABLE40;
            TRIG_OUT     <= 1'b0;

            // Requests arriving in the consuming cycle itself are kept.
            if (take) begin
                pending <= new_req;
            end else begin
                pending <= pending | new_req;
            end

            if (lose && (LOST_COUNT != 16'hFFFF)) begin
                LOST_COUNT <= LOST_COUNT + 16'd1;
            end

            unique case (state)
                IDLE: begin
                    if (take && BUF_READY) begin
                        state     <= ISSUE;
                        TRIG_TYPE <= pending;
                        TRIG_OUT  <= 1'b1;
                        BUSY      <= 1'b1;
                    end
                end
                ISSUE: begin
                    state   <= WAIT_ACK;
                    tmo_cnt <= 8'd0;
                end
                WAIT_ACK: begin
                    // An ack on the last timeout cycle still counts as an ack.
                    if (TRIG_ACK) begin
                        dcnt  <= DEAD_TIME;
                        state <= DEAD;
                    end else if (tmo_cnt == 8'hFF) begin
                        ACK_TIMEOUT <= 1'b1;
                        dcnt        <= DEAD_TIME;
                        state       <= DEAD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DEAD: begin
                    if (dcnt == '0) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        dcnt <= dcnt - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compat_trig_sched.sv
// Directed bench for compat_trig_sched. Expected triggers (type and cycle)
// are queued when stimulus is applied; a monitor pops them on TRIG_OUT.
module tb_compat_trig_sched;

    logic        CLK120 = 1'b0;
    logic        RESET;
    logic [1:0]  ENABLE40;
    logic [3:0]  TRIG_IN;
    logic [3:0]  TRIG_MASK;
    logic [11:0] DEAD_TIME;
    logic        BUF_READY;
    logic        TRIG_ACK;
    logic        TRIG_OUT;
    logic [3:0]  TRIG_TYPE;
    logic        BUSY;
    logic [15:0] LOST_COUNT;
    logic        ACK_TIMEOUT;

    typedef struct {
        logic [3:0] ttype;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cnum     = 0;
    int   ph       = 0;
    int   busy_cnt;
    int   base;

    compat_trig_sched dut (
        .CLK120      (CLK120),
        .RESET       (RESET),
        .ENABLE40    (ENABLE40),
        .TRIG_IN     (TRIG_IN),
        .TRIG_MASK   (TRIG_MASK),
        .DEAD_TIME   (DEAD_TIME),
        .BUF_READY   (BUF_READY),
        .TRIG_ACK    (TRIG_ACK),
        .TRIG_OUT    (TRIG_OUT),
        .TRIG_TYPE   (TRIG_TYPE),
        .BUSY        (BUSY),
        .LOST_COUNT  (LOST_COUNT),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    );

    always #5 CLK120 = ~CLK120;

    // Advance one cycle; ENABLE40 runs the 0,1,2 phase sequence.
    task automatic cyc();
        @(posedge CLK120);
        #1;
        ph       = (ph == 2) ? 0 : ph + 1;
        ENABLE40 = 2'(ph);
        cnum++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cnum);
    endtask

    // Move to a cycle whose ENABLE40 is 0, so the next cycle is a tick.
    task automatic to_pre_tick();
        cyc();
        while (ph != 0) cyc();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (BUSY !== 1'b0 && n < budget) begin
            cyc();
            n++;
        end
        chk(name, BUSY, 0);
    endtask

    // Single request, ack after ack_delay WAIT_ACK cycles.
    task automatic trig_ack(input string name, input logic [3:0] req, input int ack_delay);
        exp_t e;
        to_pre_tick();
        TRIG_IN = req;
        e.ttype = req;
        e.cyc   = cnum + 2;
        sb.push_back(e);
        cyc();
        TRIG_IN = 4'b0000;
        chk({name, "_busy_tick"}, BUSY, 0);
        cyc();
        chk({name, "_busy_issue"}, BUSY, 1);
        repeat (ack_delay) cyc();
        TRIG_ACK = 1'b1;
        cyc();
        TRIG_ACK = 1'b0;
        wait_idle({name, "_idle"}, 300);
    endtask

    task automatic lose_ticks(input int n);
        BUF_READY = 1'b0;
        repeat (n) begin
            to_pre_tick();
            TRIG_IN = 4'b0001;
            cyc();
            TRIG_IN = 4'b0000;
        end
        cyc();
        BUF_READY = 1'b1;
    endtask

    // Scoreboard monitor: every TRIG_OUT must match the next expectation.
    always @(negedge CLK120) begin : mon
        exp_t e;
        if (TRIG_OUT === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL trig_unexpected: got type %b at cycle %0d expected no trigger", TRIG_TYPE, cnum);
            end else begin
                e = sb.pop_front();
                if (TRIG_TYPE === e.ttype && cnum == e.cyc) n_pass++;
                else $display("FAIL trig_match: got type %b at cycle %0d expected type %b at cycle %0d",
                              TRIG_TYPE, cnum, e.ttype, e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        RESET     = 1'b1;
        ENABLE40  = 2'd0;
        TRIG_IN   = 4'b0000;
        TRIG_MASK = 4'b1111;
        DEAD_TIME = 12'd0;
        BUF_READY = 1'b1;
        TRIG_ACK  = 1'b0;
        repeat (3) cyc();
        chk("rst_busy", BUSY, 0);
        chk("rst_trig_out", TRIG_OUT, 0);
        chk("rst_trig_type", TRIG_TYPE, 0);
        chk("rst_lost", LOST_COUNT, 0);
        chk("rst_timeout", ACK_TIMEOUT, 0);
        RESET = 1'b0;

        // Single request one cycle before a tick.
        trig_ack("single", 4'b0010, 1);
        chk("single_type_held", TRIG_TYPE, 4'b0010);

        // Two requests in one 40 MHz period, with a mask change in between.
        to_pre_tick();
        cyc();
        TRIG_IN = 4'b0001;
        cyc();
        TRIG_IN   = 4'b0110;
        TRIG_MASK = 4'b0101;
        cyc();
        TRIG_IN   = 4'b0000;
        TRIG_MASK = 4'b0100;
        e.ttype = 4'b0101;
        e.cyc   = cnum + 2;
        sb.push_back(e);
        cyc();
        cyc();
        TRIG_MASK = 4'b1111;
        cyc();
        TRIG_ACK = 1'b1;
        cyc();
        TRIG_ACK = 1'b0;
        wait_idle("merge_idle", 50);
        chk("merge_lost", LOST_COUNT, 0);

        // No acknowledge: timeout after 256 WAIT_ACK cycles.
        to_pre_tick();
        TRIG_IN = 4'b0100;
        e.ttype = 4'b0100;
        e.cyc   = cnum + 2;
        sb.push_back(e);
        for (int j = 1; j <= 260; j++) begin
            cyc();
            if (j == 1) TRIG_IN = 4'b0000;
            if (j == 258) chk("tmo_not_yet", ACK_TIMEOUT, 0);
            if (j == 259) begin
                chk("tmo_set", ACK_TIMEOUT, 1);
                chk("tmo_dead_busy", BUSY, 1);
            end
            if (j == 260) chk("tmo_idle", BUSY, 0);
        end
        repeat (4) cyc();
        chk("tmo_sticky", ACK_TIMEOUT, 1);

        // Buffer not ready on three ticks.
        lose_ticks(3);
        chk("lost_three", LOST_COUNT, 3);
        lose_ticks(2);
        chk("lost_five", LOST_COUNT, 5);

        // Reset mid-DEAD, with requests present during reset.
        DEAD_TIME = 12'd20;
        to_pre_tick();
        TRIG_IN = 4'b0001;
        e.ttype = 4'b0001;
        e.cyc   = cnum + 2;
        sb.push_back(e);
        cyc();
        TRIG_IN = 4'b0000;
        cyc();
        cyc();
        TRIG_ACK = 1'b1;
        cyc();
        TRIG_ACK = 1'b0;
        cyc();
        cyc();
        chk("pre_rst_busy", BUSY, 1);
        chk("pre_rst_lost", LOST_COUNT, 5);
        chk("pre_rst_timeout", ACK_TIMEOUT, 1);
        RESET   = 1'b1;
        TRIG_IN = 4'b1111;
        cyc();
        chk("post_rst_busy", BUSY, 0);
        chk("post_rst_trig_out", TRIG_OUT, 0);
        chk("post_rst_type", TRIG_TYPE, 0);
        chk("post_rst_lost", LOST_COUNT, 0);
        chk("post_rst_timeout", ACK_TIMEOUT, 0);
        RESET   = 1'b0;
        TRIG_IN = 4'b0000;
        DEAD_TIME = 12'd0;
        repeat (6) cyc();
        chk("post_rst_quiet", BUSY, 0);

        // Continuous requests, DEAD_TIME 10, ack 5 cycles after TRIG_OUT.
        to_pre_tick();
        base      = cnum;
        TRIG_IN   = 4'b1000;
        DEAD_TIME = 12'd10;
        e.ttype = 4'b1000;
        e.cyc   = base + 2;
        sb.push_back(e);
        e.cyc   = base + 20;
        sb.push_back(e);
        busy_cnt = 0;
        for (int j = 1; j <= 19; j++) begin
            cyc();
            TRIG_ACK = (j == 7);
            if (j == 10) DEAD_TIME = 12'd3;
            if (j == 19) begin
                TRIG_IN   = 4'b0000;
                DEAD_TIME = 12'd0;
                chk("cont_idle_reentered", BUSY, 0);
            end
            if (BUSY === 1'b1) busy_cnt++;
        end
        chk("cont_busy_cycles", busy_cnt, 17);
        cyc();
        cyc();
        TRIG_ACK = 1'b1;
        cyc();
        TRIG_ACK = 1'b0;
        wait_idle("cont_second_idle", 50);
        chk("cont_lost", LOST_COUNT, 5);

        // Normal service after everything else.
        trig_ack("final", 4'b1001, 3);
        repeat (10) cyc();
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
